// File: rtl/w0rm_ifetch_responder_pkg.sv
// Shared definitions for the w0rm instruction-fetch responder:
// FSM state encoding, fault payload and halfword-select helper.
package w0rm_ifetch_responder_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_DROP = 2'd3;

   localparam logic [15:0] FAULT_INST = 16'h0000;

   // Little-endian halfword pick; caller truncates to its width.
   function automatic logic [63:0] hw_sel(
      input logic [63:0] word,
      input logic        hi,
      input int unsigned iw
   );
      return hi ? (word >> iw) : word;
   endfunction

endpackage

// File: rtl/w0rm_ifetch_line_buf.sv
// One-word line buffer: tag/data/valid, hit compare and halfword mux.
// Cleared synchronously; loaded from the memory read path.
module w0rm_ifetch_line_buf
   import w0rm_ifetch_responder_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int INST_WIDTH = 16,
   parameter int MEM_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  clear,
   input  logic                  load,
   input  logic [ADDR_WIDTH-3:0] load_tag,
   input  logic [MEM_WIDTH-1:0]  load_data,
   input  logic [ADDR_WIDTH-3:0] look_tag,
   input  logic                  look_hi,
   output logic                  hit,
   output logic [INST_WIDTH-1:0] rd_data
);

   logic                  valid_q, valid_d;
   logic [ADDR_WIDTH-3:0] tag_q, tag_d;
   logic [MEM_WIDTH-1:0]  data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         tag_d   = load_tag;
         data_d  = load_data;
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
      end
   end

   assign hit     = valid_q && (tag_q == look_tag);
   assign rd_data = INST_WIDTH'(hw_sel(64'(data_q), look_hi, INST_WIDTH));

endmodule

// File: rtl/w0rm_ifetch_responder.sv
// Fetch-side responder: classifies PCs, serves buffer hits, and runs
// the memory read FSM with flush/drop handling for misses.
module w0rm_ifetch_responder
   import w0rm_ifetch_responder_pkg::*;
#(
   parameter int                    ADDR_WIDTH    = 32,
   parameter int                    INST_WIDTH    = 16,
   parameter int                    MEM_WIDTH     = 32,
   parameter logic [ADDR_WIDTH-1:0] ROM_BASE      = 32'h2000_0000,
   parameter logic [ADDR_WIDTH-1:0] ROM_SIZE      = 32'h0001_0000,
   parameter bit                    ENABLE_BUFFER = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] fetch_addr,
   input  logic                  fetch_addr_valid,
   input  logic                  fetch_flush,
   output logic                  fetch_ready,
   output logic [INST_WIDTH-1:0] inst_data,
   output logic                  inst_valid,
   output logic                  inst_fault,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_read,
   input  logic                  mem_ready,
   input  logic [MEM_WIDTH-1:0]  mem_data_in,
   input  logic                  mem_data_valid
);

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic                  sel_q, sel_d;
   logic                  iv_q, iv_d;
   logic                  if_q, if_d;
   logic [INST_WIDTH-1:0] id_q, id_d;

   logic                  accept, is_fault, in_range;
   logic                  buf_hit, buf_load;
   logic [INST_WIDTH-1:0] buf_rd, miss_hw;
   logic [ADDR_WIDTH:0]   addr_x, lo_x, hi_x;

   // One extra bit so a window ending at 2^ADDR_WIDTH does not wrap.
   assign addr_x   = {1'b0, fetch_addr};
   assign lo_x     = {1'b0, ROM_BASE};
   assign hi_x     = lo_x + {1'b0, ROM_SIZE};
   assign in_range = (addr_x >= lo_x) && (addr_x < hi_x);
   assign is_fault = fetch_addr[0] || !in_range;

   assign fetch_ready = (state_q == ST_IDLE) && !reset;
   assign accept      = fetch_addr_valid && fetch_ready && !fetch_flush;
   assign miss_hw     = INST_WIDTH'(hw_sel(64'(mem_data_in), sel_q, INST_WIDTH));

   w0rm_ifetch_line_buf #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .INST_WIDTH (INST_WIDTH),
      .MEM_WIDTH  (MEM_WIDTH)
   ) u_line_buf (
      .clk       (clk),
      .clear     (reset),
      .load      (buf_load),
      .load_tag  (mem_addr_q[ADDR_WIDTH-1:2]),
      .load_data (mem_data_in),
      .look_tag  (fetch_addr[ADDR_WIDTH-1:2]),
      .look_hi   (fetch_addr[1]),
      .hit       (buf_hit),
      .rd_data   (buf_rd)
   );

   always_comb begin
      state_d    = state_q;
      mem_addr_d = mem_addr_q;
      sel_d      = sel_q;
      iv_d       = 1'b0;
      if_d       = 1'b0;
      id_d       = id_q;
      buf_load   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (is_fault) begin
                  iv_d = 1'b1;
                  if_d = 1'b1;
                  id_d = INST_WIDTH'(FAULT_INST);
               end else if (ENABLE_BUFFER && buf_hit) begin
                  iv_d = 1'b1;
                  id_d = buf_rd;
               end else begin
                  state_d    = ST_REQ;
                  mem_addr_d = {fetch_addr[ADDR_WIDTH-1:2], 2'b00};
                  sel_d      = fetch_addr[1];
               end
            end
         end
         ST_REQ: begin
            if (mem_ready && fetch_flush) begin
               state_d = ST_DROP;
            end else if (mem_ready) begin
               state_d = ST_WAIT;
            end else if (fetch_flush) begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (mem_data_valid) begin
               buf_load = 1'b1;
               state_d  = ST_IDLE;
               if (!fetch_flush) begin
                  iv_d = 1'b1;
                  id_d = miss_hw;
               end
            end else if (fetch_flush) begin
               state_d = ST_DROP;
            end
         end
         ST_DROP: begin
            if (mem_data_valid) begin
               buf_load = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         mem_addr_q <= '0;
         sel_q      <= 1'b0;
         iv_q       <= 1'b0;
         if_q       <= 1'b0;
         id_q       <= '0;
      end else begin
         state_q    <= state_d;
         mem_addr_q <= mem_addr_d;
         sel_q      <= sel_d;
         iv_q       <= iv_d;
         if_q       <= if_d;
         id_q       <= id_d;
      end
   end

   // A completion coincident with a flush must never be observed.
   assign inst_valid = iv_q && !fetch_flush;
   assign inst_fault = if_q && !fetch_flush;
   assign inst_data  = id_q;
   assign mem_addr   = mem_addr_q;
   assign mem_read   = (state_q == ST_REQ);

endmodule
